// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if -- bundle between the XY counter / framebuffer side and
// the VGA sync generator.
//
// Signals:
//   cuentaX     [9:0]   horizontal count from the XY counter
//   cuentaY     [9:0]   vertical count from the XY counter
//   rgb_in      [23:0]  framebuffer data, valid 1 clock after pix_addr
//   pix_addr    [18:0]  framebuffer read address, y*H_VIS+x
//   hsync, vsync        active-low sync pulses
//   video_on            high during visible pixels
//   rgb_out     [23:0]  pixel to DAC, zero outside the visible area
//   frame_start         one-clock pulse for pixel (0,0)
//   frame_cnt   [7:0]   frame counter, present only with VGA_FRAME_CNT_EN
//
// Modports:
//   slave  -- the sync generator (consumes counts/pixel data)
//   master -- the counter/framebuffer/DAC side

interface vga_sync_gen_if;
  logic [9:0]  cuentaX;
  logic [9:0]  cuentaY;
  logic [23:0] rgb_in;
  logic [18:0] pix_addr;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [23:0] rgb_out;
  logic        frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]  frame_cnt;
`endif

  modport slave (
    input  cuentaX, cuentaY, rgb_in,
    output pix_addr, hsync, vsync, video_on, rgb_out, frame_start
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport master (
    output cuentaX, cuentaY, rgb_in,
    input  pix_addr, hsync, vsync, video_on, rgb_out, frame_start
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- two-stage VGA timing decode.
//
// Stage 1 decodes the XY counts into active/hsync/vsync/frame-start flags
// and computes the framebuffer read address. Stage 2 aligns the syncs with
// the pixel data returned by the framebuffer one clock after the address,
// so every output lags the counts by exactly 2 clocks.
//
// Ports:
//   clk25  in   pixel clock, all state on its rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    vga_sync_gen_if.slave (counts, pixel data, sync/video outputs)
//
// Build option:
//   VGA_FRAME_CNT_EN -- adds bus.frame_cnt, an 8-bit wrapping count of
//   frame_start pulses. Without it the counter does not exist.

module vga_sync_gen #(
  parameter int H_VIS = 640,
  parameter int H_FP  = 16,
  parameter int H_SW  = 96,
  parameter int V_VIS = 480,
  parameter int V_FP  = 10,
  parameter int V_SW  = 2
) (
  input  logic           clk25,
  input  logic           rst_n,
  vga_sync_gen_if.slave  bus
);

  // Comparisons are done at 32 bits unsigned so out-of-range counts (up to
  // 1023) never wrap into a sync or active window.
  localparam logic [31:0] H_VIS_U   = 32'(H_VIS);
  localparam logic [31:0] H_SS_U    = 32'(H_VIS + H_FP);
  localparam logic [31:0] H_SE_U    = 32'(H_VIS + H_FP + H_SW);
  localparam logic [31:0] V_VIS_U   = 32'(V_VIS);
  localparam logic [31:0] V_SS_U    = 32'(V_VIS + V_FP);
  localparam logic [31:0] V_SE_U    = 32'(V_VIS + V_FP + V_SW);
  localparam logic [18:0] H_VIS_19  = 19'(H_VIS);

  logic [31:0] x_ext;
  logic [31:0] y_ext;
  logic        act_nxt;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        fs_nxt;
  logic [18:0] addr_nxt;

  assign x_ext = {22'd0, bus.cuentaX};
  assign y_ext = {22'd0, bus.cuentaY};

  always_comb begin
    act_nxt  = (x_ext < H_VIS_U) && (y_ext < V_VIS_U);
    hs_nxt   = !((x_ext >= H_SS_U) && (x_ext < H_SE_U));
    vs_nxt   = !((y_ext >= V_SS_U) && (y_ext < V_SE_U));
    fs_nxt   = (bus.cuentaX == 10'd0) && (bus.cuentaY == 10'd0);
    addr_nxt = 19'd0;
    // Only computed for visible pixels, where y*H_VIS+x fits in 19 bits.
    if (act_nxt) begin
      addr_nxt = 19'(bus.cuentaY) * H_VIS_19 + 19'(bus.cuentaX);
    end
  end

  // Stage 1
  logic act_s1;
  logic hs_s1;
  logic vs_s1;
  logic fs_s1;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      act_s1       <= 1'b0;
      hs_s1        <= 1'b1;
      vs_s1        <= 1'b1;
      fs_s1        <= 1'b0;
      bus.pix_addr <= 19'd0;
    end else begin
      act_s1       <= act_nxt;
      hs_s1        <= hs_nxt;
      vs_s1        <= vs_nxt;
      fs_s1        <= fs_nxt;
      bus.pix_addr <= addr_nxt;
    end
  end

  // Stage 2: rgb_in arriving now belongs to the address issued by stage 1.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      bus.hsync       <= 1'b1;
      bus.vsync       <= 1'b1;
      bus.video_on    <= 1'b0;
      bus.rgb_out     <= 24'h0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.hsync       <= hs_s1;
      bus.vsync       <= vs_s1;
      bus.video_on    <= act_s1;
      bus.rgb_out     <= act_s1 ? bus.rgb_in : 24'h0;
      bus.frame_start <= fs_s1;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Advances on the same edge frame_start rises, so the count already
  // includes the frame being announced.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      bus.frame_cnt <= 8'd0;
    end else if (fs_s1) begin
      bus.frame_cnt <= bus.frame_cnt + 8'd1;
    end
  end
`endif

endmodule
